// File: rtl/stream_demux_pkg.sv
// Shared types and parameter defaults for the stream demultiplexer.
`include "stream_demux_defs.vh"

package stream_demux_pkg;

  localparam int DEF_DATA_W = `SD_DATA_W;
  localparam int DEF_N_CH   = `SD_N_CH;
  localparam int DEF_CNT_W  = `SD_CNT_W;

  // How the word currently offered at the input is routed.
  typedef enum logic [1:0] {
    ROUTE_UNI   = 2'd0,
    ROUTE_BCAST = 2'd1,
    ROUTE_DROP  = 2'd2
  } route_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel of the demultiplexer.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              out_ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load in the same cycle as a drain replaces the word and keeps valid high.
  always_comb begin
    valid_d = valid_q & ~out_ready_i;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = ~valid_q | out_ready_i;

endmodule

// File: rtl/stream_demux_defs.vh
// Shared defaults and helper macro for the stream demultiplexer.
`ifndef STREAM_DEMUX_DEFS_VH
`define STREAM_DEMUX_DEFS_VH

`define SD_DATA_W 8
`define SD_N_CH   8
`define SD_CNT_W  8
`define SD_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

`endif

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel holding slots,
// broadcast mode and a saturating count of out-of-range words.
`include "stream_demux_defs.vh"

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH,
  parameter int SEL_W  = `SD_CLOG2(N_CH),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  input  logic [DATA_W-1:0]      in_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  route_e          route;
  logic            in_range;
  logic            accept;
  logic [N_CH-1:0] free;
  logic [N_CH-1:0] uni_hit;
  logic [N_CH-1:0] load;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign in_range = ({1'b0, in_sel} < N_CH_L);

  always_comb begin
    route = ROUTE_UNI;
    if (in_bcast)       route = ROUTE_BCAST;
    else if (!in_range) route = ROUTE_DROP;
  end

  // Ready is a function of slot state and routing only, never of in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (route)
      ROUTE_BCAST: in_ready = &free;
      ROUTE_UNI:   in_ready = |(free & uni_hit);
      default:     in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && route == ROUTE_DROP) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    assign uni_hit[k] = (in_sel == SEL_W'(k));
    assign load[k]    = accept & ((route == ROUTE_BCAST) |
                                  ((route == ROUTE_UNI) & uni_hit[k]));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load[k]),
      .data_i      (in_data),
      .out_ready_i (out_ready[k]),
      .valid_o     (out_valid[k]),
      .data_o      (out_data[k*DATA_W +: DATA_W]),
      .free_o      (free[k])
    );
  end

endmodule
